pipe_stage_slice: RTL

- Parametrised pipeline stage register for the CPU pipeline. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches into one reusable slice.
- Each slice carries a valid/ready handshake, a per-stage hold, a flush, and an optional 2-entry skid buffer that breaks the combinational ready path.
- It zeroes control bits on bubbles so squashed instructions cannot write state.
- Saturating stall and bubble counters feed performance monitoring.

---
 rtl/cpu_pipe_pkg.sv | 21 ++
 rtl/pipe_sat_counter.sv | 25 ++
 rtl/pipe_stage_slice.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared types and per-stage widths for the CPU pipeline latches.
// The state encoding is common to every pipe_stage_slice instance.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  // Widths used when the slice replaces the fixed IF/ID, ID/EX, EX/MEM, MEM/WB latches
  localparam int IFID_CTRL_W  = 4;
  localparam int IFID_DATA_W  = 96;
  localparam int IDEX_CTRL_W  = 12;
  localparam int IDEX_DATA_W  = 224;
  localparam int EXMEM_CTRL_W = 8;
  localparam int EXMEM_DATA_W = 160;
  localparam int MEMWB_CTRL_W = 4;
  localparam int MEMWB_DATA_W = 96;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count up to all-ones and stick there until cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/pipe_stage_slice.sv
// Reusable pipeline stage register: valid/ready handshake, hold, flush,
// optional 2-entry skid buffer, control zeroing on bubbles and perf counters.
module pipe_stage_slice
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [DATA_W-1:0] dn_data,
  input  logic              hold,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_e       state, stateNext;
  logic [CTRL_W-1:0] mainCtrl, mainCtrlNext, skidCtrl, skidCtrlNext;
  logic [DATA_W-1:0] mainData, mainDataNext, skidData, skidDataNext;
  logic              iv, upFire, dnFire;

  assign iv       = (state != ST_EMPTY);
  assign dn_valid = iv & ~hold;
  assign dn_ctrl  = dn_valid ? mainCtrl : {CTRL_W{1'b0}};
  assign dn_data  = mainData;
  assign upFire   = up_valid & up_ready;
  assign dnFire   = dn_valid & dn_ready;

  // With the skid buffer, up_ready comes from state alone so no ready path crosses the stage
  if (SKID != 0) begin : gSkidReady
    assign up_ready = (state != ST_SKID) & ~hold & ~rst;
  end else begin : gCombReady
    assign up_ready = ~hold & (~iv | dn_ready) & ~rst;
  end

  // Next-state and entry load selection; flush discards any same-cycle accept
  always_comb begin
    stateNext    = state;
    mainCtrlNext = mainCtrl;
    mainDataNext = mainData;
    skidCtrlNext = skidCtrl;
    skidDataNext = skidData;
    if (flush) begin
      stateNext = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (upFire) begin
            stateNext    = ST_FULL;
            mainCtrlNext = up_ctrl;
            mainDataNext = up_data;
          end else begin
            stateNext = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (upFire && dnFire) begin
            stateNext    = ST_FULL;
            mainCtrlNext = up_ctrl;
            mainDataNext = up_data;
          end else if (dnFire) begin
            stateNext = ST_EMPTY;
          end else if (upFire && (SKID != 0)) begin
            stateNext    = ST_SKID;
            skidCtrlNext = up_ctrl;
            skidDataNext = up_data;
          end else begin
            stateNext = ST_FULL;
          end
        end
        ST_SKID: begin
          if (dnFire) begin
            stateNext    = ST_FULL;
            mainCtrlNext = skidCtrl;
            mainDataNext = skidData;
          end else begin
            stateNext = ST_SKID;
          end
        end
        default: begin
          stateNext = ST_EMPTY;
        end
      endcase
    end
  end

  // State and entry registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      mainCtrl <= {CTRL_W{1'b0}};
      mainData <= {DATA_W{1'b0}};
      skidCtrl <= {CTRL_W{1'b0}};
      skidData <= {DATA_W{1'b0}};
    end else begin
      state    <= stateNext;
      mainCtrl <= mainCtrlNext;
      mainData <= mainDataNext;
      skidCtrl <= skidCtrlNext;
      skidData <= skidDataNext;
    end
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk (clk),
    .rst (rst),
    .inc (iv & ~(dn_ready & ~hold)),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) uBubbleCnt (
    .clk (clk),
    .rst (rst),
    .inc (~dn_valid),
    .clr (cnt_clr),
    .cnt (bubble_cnt)
  );

endmodule
